uart_csr: RTL and testbench

UART_CSR -- requirements
Module: uart_csr

---
 rtl/uart_csr.sv | 159 +++++++++++++++
 tb/tb_uart_csr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr.sv
// uart_csr: APB control/status block for a UART core.
// Holds the configuration word, sticky error flags with saturating counters,
// the interrupt mask, and a serial restoring divider that turns
// clock-kHz * 1000 / baud into a clocks-per-bit divisor.
//
// Divider FSM
//   state | meaning
//   IDLE  | no division in flight, divisor_o holds the last result
//   RUN   | one quotient bit per cycle, 24 cycles, div_busy = 1
module uart_csr #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8,
    parameter int KHZ_W  = 14,
    parameter int BAUD_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [31:0]       prdata_o,
    input  logic              stop_err_i,
    input  logic              parity_err_i,
    input  logic              overrun_err_i,
    output logic              enable_o,
    output logic              irq_o,
    output logic [23:0]       divisor_o,
    output logic              divisor_valid_o
);

    typedef enum logic {IDLE, RUN} state_t;

    logic              access, mapped, wr_ok;
    logic              sel_status, sel_cfg, sel_irq_en, sel_div;
    logic [31:0]       cfg;
    logic [2:0]        irq_en;
    logic [2:0]        sticky, pulse, clr;
    logic [CNT_W-1:0]  cnt_stop, cnt_par;
    logic [31:0]       status_word;

    state_t            state;
    logic [4:0]        div_cnt;
    logic [23:0]       quo, quo_nx, n_load, khz_ext;
    logic [BAUD_W-1:0] dvs, rem, rem_nx, diff, baud_w;
    logic [KHZ_W-1:0]  khz_w;
    logic [BAUD_W:0]   rem_sh;
    logic              ge;

    // APB decode: full-width compare so aliases of the four registers error out
    assign access     = psel_i & penable_i;
    assign sel_status = (paddr_i == ADDR_W'(8'h00));
    assign sel_cfg    = (paddr_i == ADDR_W'(8'h04));
    assign sel_irq_en = (paddr_i == ADDR_W'(8'h08));
    assign sel_div    = (paddr_i == ADDR_W'(8'h0C));
    assign mapped     = sel_status | sel_cfg | sel_irq_en | sel_div;
    assign pready_o   = access;
    assign pslverr_o  = access & (~mapped | (pwrite_i & sel_div));
    assign wr_ok      = access & pwrite_i & ~pslverr_o;

    assign enable_o    = cfg[0];
    assign status_word = {8'h00, 8'(cnt_par), 8'(cnt_stop), 4'h0,
                          (state == RUN), sticky};

    // Read mux, driven only during a clean read access phase
    always_comb begin
        prdata_o = 32'h0;
        if (access && !pwrite_i) begin
            if (sel_status)      prdata_o = status_word;
            else if (sel_cfg)    prdata_o = cfg;
            else if (sel_irq_en) prdata_o = {29'h0, irq_en};
            else if (sel_div)    prdata_o = {divisor_valid_o, 7'h00, divisor_o};
        end
    end

    // Configuration and interrupt-mask registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg    <= 32'h0;
            irq_en <= 3'b000;
        end else begin
            if (wr_ok && sel_cfg)    cfg    <= pwdata_i;
            if (wr_ok && sel_irq_en) irq_en <= pwdata_i[2:0];
        end
    end

    // Sticky flags and counters; a pulse coincident with its clear wins
    assign pulse = {overrun_err_i, parity_err_i, stop_err_i};
    assign clr   = (wr_ok && sel_status) ? pwdata_i[2:0] : 3'b000;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky   <= 3'b000;
            cnt_stop <= '0;
            cnt_par  <= '0;
            irq_o    <= 1'b0;
        end else begin
            sticky <= (sticky & ~clr) | pulse;
            if (clr[0])                            cnt_stop <= CNT_W'(pulse[0]);
            else if (pulse[0] && cnt_stop != '1)   cnt_stop <= cnt_stop + 1'b1;
            if (clr[1])                            cnt_par  <= CNT_W'(pulse[1]);
            else if (pulse[1] && cnt_par != '1)    cnt_par  <= cnt_par + 1'b1;
            irq_o <= |(sticky & irq_en);
        end
    end

    // Operands come straight from the write data since cfg updates on the same edge
    assign baud_w  = pwdata_i[1 +: BAUD_W];
    assign khz_w   = pwdata_i[1 + BAUD_W +: KHZ_W];
    assign khz_ext = 24'(khz_w);
    assign n_load  = khz_ext * 24'd1000;

    // Remainder stays below the divisor, so BAUD_W bits hold it between steps
    assign rem_sh = {rem, quo[23]};
    assign ge     = (rem_sh >= {1'b0, dvs});
    assign diff   = rem_sh[BAUD_W-1:0] - dvs;
    assign rem_nx = ge ? diff : rem_sh[BAUD_W-1:0];
    assign quo_nx = {quo[22:0], ge};

    // Divider FSM; a CFG write always (re)starts from the new operands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            div_cnt         <= 5'd0;
            quo             <= 24'h0;
            rem             <= '0;
            dvs             <= '0;
            divisor_o       <= 24'h0;
            divisor_valid_o <= 1'b0;
        end else if (wr_ok && sel_cfg) begin
            if (baud_w == '0) begin
                state           <= IDLE;
                divisor_o       <= 24'hFFFFFF;
                divisor_valid_o <= 1'b1;
            end else begin
                state           <= RUN;
                div_cnt         <= 5'd23;
                quo             <= n_load;
                rem             <= '0;
                dvs             <= baud_w;
                divisor_valid_o <= 1'b0;
            end
        end else if (state == RUN) begin
            quo <= quo_nx;
            rem <= rem_nx;
            if (div_cnt == 5'd0) begin
                state           <= IDLE;
                divisor_o       <= quo_nx;
                divisor_valid_o <= 1'b1;
            end else begin
                div_cnt <= div_cnt - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_csr.sv
// Bench for uart_csr: directed sequence with randomized operands, checked
// against a behavioural model of the register map, counters and divider.
`timescale 1ns/1ps
module tb_uart_csr;

    localparam logic [11:0] A_STATUS = 12'h000;
    localparam logic [11:0] A_CFG    = 12'h004;
    localparam logic [11:0] A_IRQ    = 12'h008;
    localparam logic [11:0] A_DIV    = 12'h00C;

    logic        clk = 1'b0, rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        stop_err = 1'b0, parity_err = 1'b0, overrun_err = 1'b0;
    logic        enable, irq, divisor_valid;
    logic [23:0] divisor;

    int n_pass = 0, n_chk = 0, cyc = 0;

    // reference model state
    logic [2:0]  m_sticky = '0;
    int          m_stop = 0, m_par = 0;
    logic [31:0] m_cfg = '0;
    logic [2:0]  m_en = '0;
    logic [23:0] m_div = '0;

    uart_csr dut (
        .clk_i(clk), .rst_i(rst),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
        .stop_err_i(stop_err), .parity_err_i(parity_err), .overrun_err_i(overrun_err),
        .enable_o(enable), .irq_o(irq),
        .divisor_o(divisor), .divisor_valid_o(divisor_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [23:0] exp_div(input logic [31:0] c);
        longint khz, baud, n;
        khz  = longint'(c[31:18]);
        baud = longint'(c[17:1]);
        if (baud == 0) return 24'hFFFFFF;
        n = (khz * 1000) % (longint'(1) << 24);
        return 24'(n / baud);
    endfunction

    function automatic logic [31:0] m_status(input logic busy);
        return {8'h00, 8'(m_par), 8'(m_stop), 4'h0, busy, m_sticky};
    endfunction

    function automatic logic [31:0] cfg_rand();
        logic [13:0] khz;
        logic [16:0] baud;
        khz  = 14'($urandom_range(0, 16383));
        baud = ($urandom_range(0, 3) == 0) ? 17'($urandom_range(1, 40))
                                           : 17'($urandom_range(1, 131071));
        return {khz, baud, 1'($urandom_range(0, 1))};
    endfunction

    // one clock edge of error-pulse / W1C behaviour
    task automatic m_edge(input logic [2:0] p, input logic [2:0] w1c);
        for (int i = 0; i < 3; i++) begin
            if (w1c[i])    m_sticky[i] = p[i];
            else if (p[i]) m_sticky[i] = 1'b1;
        end
        if (w1c[0])                    m_stop = p[0] ? 1 : 0;
        else if (p[0] && m_stop < 255) m_stop++;
        if (w1c[1])                    m_par = p[1] ? 1 : 0;
        else if (p[1] && m_par < 255)  m_par++;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [2:0] p = 3'b000);
        logic e;
        e = !(a == A_STATUS || a == A_CFG || a == A_IRQ);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        {overrun_err, parity_err, stop_err} = p;
        #1;
        chk("wr_pready", pready, 1);
        chk("wr_pslverr", pslverr, e);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        {overrun_err, parity_err, stop_err} = 3'b000;
        m_edge(p, (a == A_STATUS) ? d[2:0] : 3'b000);
        if (a == A_CFG) m_cfg = d;
        if (a == A_IRQ) m_en = d[2:0];
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic e;
        e = !(a == A_STATUS || a == A_CFG || a == A_IRQ || a == A_DIV);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1;
        chk({tag, "_setup_data"}, prdata, 0);
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk({tag, "_pslverr"}, pslverr, e);
        chk(tag, prdata, e ? 32'h0 : exp);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse(input logic [2:0] p);
        @(negedge clk);
        {overrun_err, parity_err, stop_err} = p;
        @(posedge clk);
        #1;
        {overrun_err, parity_err, stop_err} = 3'b000;
        m_edge(p, 3'b000);
    endtask

    task automatic wait_valid(input string tag, input int t0);
        int i;
        i = 0;
        while (!divisor_valid && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk({tag, "_latency"}, cyc - t0, 24);
    endtask

    initial begin
        logic [31:0] c, cb;
        logic [2:0]  p;
        int          t0;
        bit          seen;

        // reset: outputs cleared, pready follows inputs, writes ignored
        repeat (2) @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = A_CFG; pwdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_pready", pready, 1);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("rst_irq", irq, 0);
        chk("rst_valid", divisor_valid, 0);
        chk("rst_divisor", divisor, 0);
        chk("rst_enable", enable, 0);
        @(negedge clk);
        rst = 1'b0;
        rd("rst_status", A_STATUS, 0);
        rd("rst_cfg", A_CFG, 0);
        rd("rst_irq_en", A_IRQ, 0);
        rd("rst_div", A_DIV, 0);

        // reference configuration: 10 MHz, 115200 baud
        c = {14'd10000, 17'd115200, 1'b1};
        wr(A_CFG, c);
        t0 = cyc;
        chk("ref_valid_fall", divisor_valid, 0);
        chk("ref_hold", divisor, 0);
        rd("ref_busy", A_STATUS, m_status(1'b1));
        wait_valid("ref", t0);
        m_div = exp_div(c);
        chk("ref_divisor", divisor, 86);
        chk("ref_enable", enable, 1);
        rd("ref_div_reg", A_DIV, {1'b1, 7'h00, m_div});
        rd("ref_cfg", A_CFG, c);
        rd("ref_idle", A_STATUS, m_status(1'b0));

        // random configurations, last one with baud = 0
        for (int k = 0; k < 6; k++) begin
            c = cfg_rand();
            if (k == 5) c[17:1] = '0;
            wr(A_CFG, c);
            t0 = cyc;
            if (c[17:1] == '0) begin
                m_div = 24'hFFFFFF;
                chk("zero_valid", divisor_valid, 1);
                chk("zero_divisor", divisor, 24'hFFFFFF);
            end else begin
                chk("rnd_valid_fall", divisor_valid, 0);
                chk("rnd_hold", divisor, m_div);
                wait_valid("rnd", t0);
                m_div = exp_div(c);
                chk("rnd_divisor", divisor, m_div);
            end
            chk("rnd_enable", enable, c[0]);
            rd("rnd_cfg", A_CFG, m_cfg);
        end

        // restart mid-division: old result discarded
        c  = cfg_rand();
        cb = cfg_rand();
        wr(A_CFG, c);
        repeat (5) @(posedge clk);
        #1;
        wr(A_CFG, cb);
        t0 = cyc;
        chk("restart_valid", divisor_valid, 0);
        wait_valid("restart", t0);
        m_div = exp_div(cb);
        chk("restart_divisor", divisor, m_div);

        // 300 stop errors saturate, then W1C
        for (int k = 0; k < 300; k++) pulse(3'b001);
        rd("stop_sat", A_STATUS, m_status(1'b0));
        wr(A_STATUS, 32'h1);
        rd("stop_clr", A_STATUS, m_status(1'b0));

        // random error traffic
        for (int k = 0; k < 200; k++) begin
            p = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            pulse(p);
        end
        rd("rnd_err", A_STATUS, m_status(1'b0));
        wr(A_STATUS, 32'h2, 3'b010);
        rd("par_coincident", A_STATUS, m_status(1'b0));

        // interrupt: lags STATUS & IRQ_EN by one register stage
        wr(A_STATUS, 32'h7);
        wr(A_IRQ, 32'h4);
        rd("irq_en", A_IRQ, 32'h4);
        pulse(3'b100);
        chk("irq_lag", irq, 0);
        @(posedge clk);
        #1;
        chk("irq_set", irq, 1);
        pulse(3'b001);
        chk("irq_hold", irq, 1);
        wr(A_STATUS, 32'h4);
        chk("irq_clr_lag", irq, 1);
        @(posedge clk);
        #1;
        chk("irq_masked", irq, 0);

        // slave errors, no state change
        rd("unmapped_rd", 12'h010, 0);
        wr(A_DIV, 32'hDEAD_BEEF);
        wr(12'h010, 32'hFFFF_FFFF);
        wr(12'h104, 32'hFFFF_FFFF);
        rd("err_div", A_DIV, {1'b1, 7'h00, m_div});
        rd("err_cfg", A_CFG, m_cfg);
        rd("err_irq_en", A_IRQ, {29'h0, m_en});
        rd("err_status", A_STATUS, m_status(1'b0));
        wr(A_CFG, {14'd100, 17'd0, 1'b1});
        chk("baud0_valid", divisor_valid, 1);
        chk("baud0_divisor", divisor, 24'hFFFFFF);

        // reset at RUN cycle 10 aborts the division
        c = cfg_rand();
        wr(A_CFG, c);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_divisor_async", divisor, 0);
        chk("abort_valid_async", divisor_valid, 0);
        m_sticky = '0; m_stop = 0; m_par = 0; m_cfg = '0; m_en = '0; m_div = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (divisor_valid) seen = 1'b1;
        end
        chk("abort_no_publish", seen, 0);
        chk("abort_irq", irq, 0);
        chk("abort_enable", enable, 0);
        rd("abort_status", A_STATUS, m_status(1'b0));
        rd("abort_cfg", A_CFG, 0);
        rd("abort_irq_en", A_IRQ, 0);
        rd("abort_div", A_DIV, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
